// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_if.sv
// Word handshake, bit strobe and serial link signals of the PISO transmitter.
interface piso_if #(
    parameter int WIDTH = 4
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output load_valid,
        output parallel_in,
        output shift_en,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  last_bit,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  parallel_in,
        input  shift_en,
        output load_ready,
        output serial_out,
        output serial_valid,
        output last_bit,
        output busy
    );

endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a word on a valid/ready handshake
// and shifts it out LSB first, one bit per shift_en strobe.
//
// state | meaning
// IDLE  | no word held, ready for a load
// SHIFT | word held in sh, cnt indexes the bit on the link
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    piso_if.slave bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             at_last;
    logic             ready;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Ready on the last enabled bit lets the next word follow with no gap.
    always_comb begin
        at_last = (state == SHIFT) && (cnt == CNT_LAST);
        ready   = (state == IDLE) || (at_last && bus.shift_en);
        accept  = bus.load_valid && ready;
    end

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SHIFT;
            sh_nxt    = bus.parallel_in;
            cnt_nxt   = '0;
        end else if (state == SHIFT && bus.shift_en) begin
            if (at_last) begin
                state_nxt = IDLE;
                sh_nxt    = '0;
                cnt_nxt   = '0;
            end else begin
                sh_nxt  = sh >> 1;
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    assign bus.load_ready   = ready;
    assign bus.serial_out   = (state == SHIFT) && sh[0];
    assign bus.serial_valid = (state == SHIFT);
    assign bus.busy         = (state == SHIFT);
    assign bus.last_bit     = at_last;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed 4-bit vectors with a SIPO loopback,
// async reset abort, and randomized 8-bit traffic against a word-queue model.
module tb_piso_tx;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    piso_if #(.WIDTH(4)) if4 ();
    piso_if #(.WIDTH(8)) if8 ();

    piso_tx #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    piso_tx #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       lv;
        logic [3:0] pi;
        logic       en;
        logic       e_ready;
        logic       e_sout;
        logic       e_busy;
        logic       e_last;
        logic       chk_rx;
        logic [3:0] e_rx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // 4-bit receive register sampling on the same strobes as the link.
    logic [3:0] rx4;
    always @(posedge clk or posedge reset) begin
        if (reset) rx4 <= '0;
        else if (if4.shift_en && if4.serial_valid) rx4 <= {if4.serial_out, rx4[3:1]};
    end

    // 8-bit loopback model: accepted words queue up, received words must match in order.
    logic       rnd_on = 1'b0;
    logic [7:0] sent[$];
    logic [7:0] rx8 = '0;
    int         nbits = 0;
    int         words_rx = 0;

    always @(posedge clk) begin
        if (rnd_on && !reset) begin
            if (if8.load_valid && if8.load_ready) sent.push_back(if8.parallel_in);
            if (if8.serial_valid && if8.shift_en) begin
                rx8 = {if8.serial_out, rx8[7:1]};
                check("w8_last_bit", int'(if8.last_bit), int'(nbits == 7));
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    words_rx++;
                    if (sent.size() != 0) begin
                        check("w8_word", int'(rx8), int'(sent.pop_front()));
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL w8_word: got %0h expected no word pending", rx8);
                    end
                end
            end
        end
    end

    function automatic void add(input string nm, input logic rst, input logic lv,
                                input logic [3:0] pi, input logic en, input logic rdy,
                                input logic so, input logic bsy, input logic lb,
                                input logic crx, input logic [3:0] erx);
        vec_t v;
        v.name = nm; v.rst = rst; v.lv = lv; v.pi = pi; v.en = en;
        v.e_ready = rdy; v.e_sout = so; v.e_busy = bsy; v.e_last = lb;
        v.chk_rx = crx; v.e_rx = erx;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic rst, input logic lv, input logic [3:0] pi, input logic en);
        @(negedge clk);
        reset           = rst;
        if4.load_valid  = lv;
        if4.parallel_in = pi;
        if4.shift_en    = en;
        #1;
    endtask

    task automatic expect4(input string nm, input logic rdy, input logic so,
                           input logic bsy, input logic lb);
        check({nm, "_ready"},  int'(if4.load_ready),   int'(rdy));
        check({nm, "_sout"},   int'(if4.serial_out),   int'(so));
        check({nm, "_svalid"}, int'(if4.serial_valid), int'(bsy));
        check({nm, "_busy"},   int'(if4.busy),         int'(bsy));
        check({nm, "_last"},   int'(if4.last_bit),     int'(lb));
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] w2;
        logic       en;
        int         b;

        if4.load_valid = 1'b0; if4.parallel_in = '0; if4.shift_en = 1'b0;
        if8.load_valid = 1'b0; if8.parallel_in = '0; if8.shift_en = 1'b0;

        // Reset, then 1011 at full rate.
        add("t1_rst", 1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0);
        add("t1_rst", 1, 0, 4'h0, 1, 1, 0, 0, 0, 0, 4'h0);
        add("t1_load", 0, 1, 4'hB, 1, 1, 0, 0, 0, 0, 4'h0);
        w = 4'b1011;
        for (int i = 0; i < 4; i++) add("t1_bit", 0, 0, 4'h0, 1, i == 3, w[i], 1, i == 3, 0, 4'h0);
        add("t1_done", 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 4'hB);

        // A then 5 offered throughout: gapless back-to-back.
        add("t2_loadA", 0, 1, 4'hA, 1, 1, 0, 0, 0, 0, 4'h0);
        w = 4'hA; w2 = 4'h5;
        for (int i = 0; i < 4; i++) add("t2_a", 0, 1, 4'h5, 1, i == 3, w[i], 1, i == 3, 0, 4'h0);
        for (int i = 0; i < 4; i++) add("t2_b", 0, 0, 4'h0, 1, i == 3, w2[i], 1, i == 3, 0, 4'h0);
        add("t2_done", 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 4'h5);

        // C with a strobe every third cycle: 12 busy cycles.
        add("t3_load", 0, 1, 4'hC, 1, 1, 0, 0, 0, 0, 4'h0);
        w = 4'hC;
        for (int k = 0; k < 12; k++) begin
            b  = k / 3;
            en = (k % 3 == 2);
            add("t3_bit", 0, 0, 4'h0, en, (b == 3) && en, w[b], 1, b == 3, 0, 4'h0);
        end
        add("t3_done", 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 4'hC);

        // F offered mid-word of 0: ignored until the last bit.
        add("t4_load0", 0, 1, 4'h0, 1, 1, 0, 0, 0, 0, 4'h0);
        add("t4_b0", 0, 0, 4'h0, 1, 0, 0, 1, 0, 0, 4'h0);
        add("t4_b1", 0, 1, 4'hF, 1, 0, 0, 1, 0, 0, 4'h0);
        add("t4_b2", 0, 1, 4'hF, 1, 0, 0, 1, 0, 0, 4'h0);
        add("t4_b3", 0, 1, 4'hF, 1, 1, 0, 1, 1, 0, 4'h0);
        add("t4_f0", 0, 0, 4'h0, 1, 0, 1, 1, 0, 1, 4'h0);
        add("t4_f1", 0, 0, 4'h0, 1, 0, 1, 1, 0, 0, 4'h0);
        add("t4_f2", 0, 0, 4'h0, 1, 0, 1, 1, 0, 0, 4'h0);
        add("t4_f3", 0, 0, 4'h0, 1, 1, 1, 1, 1, 0, 4'h0);
        add("t4_done", 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 4'hF);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].lv, vecs[i].pi, vecs[i].en);
            expect4(vecs[i].name, vecs[i].e_ready, vecs[i].e_sout, vecs[i].e_busy, vecs[i].e_last);
            if (vecs[i].chk_rx) check({vecs[i].name, "_rx"}, int'(rx4), int'(vecs[i].e_rx));
        end

        // Async reset during bit 2 of 6, then a fresh 9.
        step(0, 1, 4'h6, 1); expect4("t5_load", 1, 0, 0, 0);
        step(0, 0, 4'h0, 1); expect4("t5_b0", 0, 0, 1, 0);
        step(0, 0, 4'h0, 1); expect4("t5_b1", 0, 1, 1, 0);
        step(0, 0, 4'h0, 1); expect4("t5_b2", 0, 1, 1, 0);
        #1 reset = 1'b1;
        #1 expect4("t5_abort", 1, 0, 0, 0);
        step(1, 1, 4'h9, 1); expect4("t5_hold", 1, 0, 0, 0);
        step(0, 1, 4'h9, 1); expect4("t5_load9", 1, 0, 0, 0);
        w = 4'h9;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'h0, 1);
            expect4("t5_bit", i == 3, w[i], 1, i == 3);
        end
        step(0, 0, 4'h0, 0); expect4("t5_done", 1, 0, 0, 0);
        check("t5_rx", int'(rx4), 9);

        // Randomized 8-bit traffic with random strobes.
        @(negedge clk);
        rnd_on = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if8.shift_en    = ($urandom_range(0, 3) != 0);
            if8.load_valid  = ($urandom_range(0, 2) != 0);
            if8.parallel_in = 8'($urandom);
        end
        @(negedge clk);
        if8.load_valid = 1'b0;
        if8.shift_en   = 1'b1;
        repeat (20) @(negedge clk);
        check("w8_drained", sent.size(), 0);
        check("w8_enough_words", int'(words_rx >= 20), 1);
        check("w8_idle", int'(if8.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
